rr_arb_mux: RTL

- Parametrised N-input arbitrated multiplexer with valid/ready handshakes and a one-entry registered output stage.
- Successor to the fixed 2/4/8/16-way combinational muxes: channel count and width are parameters, selection is by an internal arbiter rather than an external select, and the result is held until the consumer accepts it.
- Sits in front of shared resources: cache request ports, memory bus, writeback path.

---
 rtl/mux_pkg.sv | 15 +
 rtl/rr_arbiter.sv | 55 +++++
 rtl/rr_arb_mux.sv | 109 ++++++++++
 3 files changed

// File: rtl/mux_pkg.sv
// Shared types and helpers for the arbitrated multiplexer family.
package mux_pkg;

  // Arbitration policy applied when several channels request together.
  typedef enum logic {
    ARB_RR    = 1'b0,
    ARB_FIXED = 1'b1
  } arb_mode_e;

  // Width of a channel index; a single channel still needs one bit.
  function automatic int sel_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational N-way arbiter: round-robin from a start pointer or fixed
// priority with index 0 highest. Produces both one-hot and encoded grants.
module rr_arbiter
  import mux_pkg::*;
#(
  parameter int        N     = 4,
  parameter arb_mode_e MODE  = ARB_RR,
  localparam int       SEL_W = sel_width(N)
) (
  input  logic [N-1:0]     req,
  input  logic [SEL_W-1:0] ptr,
  input  logic             en,
  output logic [N-1:0]     gnt_onehot,
  output logic [SEL_W-1:0] gnt_idx,
  output logic             gnt_any
);

  logic [SEL_W-1:0] base;
  logic [2*N-1:0]   req_dbl;
  logic [N-1:0]     req_rot;
  logic [SEL_W:0]   idx_sum;

  // Fixed priority is round-robin with the search always starting at 0.
  assign base    = (MODE == ARB_RR) ? ptr : '0;
  // Doubling the request vector turns the circular search into a shift.
  assign req_dbl = {req, req};
  assign req_rot = N'(req_dbl >> base);

  // Lowest set bit of the rotated vector wins; map it back to a channel index.
  always_comb begin
    gnt_any = 1'b0;
    gnt_idx = '0;
    idx_sum = '0;
    if (en) begin
      for (int i = N - 1; i >= 0; i--) begin
        if (req_rot[i]) begin
          gnt_any = 1'b1;
          idx_sum = {1'b0, base} + (SEL_W + 1)'(i);
          if (idx_sum >= (SEL_W + 1)'(N)) begin
            idx_sum = idx_sum - (SEL_W + 1)'(N);
          end
          gnt_idx = idx_sum[SEL_W-1:0];
        end
      end
    end
  end

  // One-hot view of the encoded grant, one compare per channel.
  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_onehot
      assign gnt_onehot[gi] = gnt_any && (gnt_idx == SEL_W'(gi));
    end
  endgenerate

endmodule

// File: rtl/rr_arb_mux.sv
// N-input arbitrated multiplexer with valid/ready handshakes on every channel
// and a one-entry registered output stage that sustains one beat per cycle.
module rr_arb_mux
  import mux_pkg::*;
#(
  parameter int        WIDTH = 32,
  parameter int        N     = 4,
  parameter arb_mode_e MODE  = ARB_RR,
  localparam int       SEL_W = sel_width(N)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [N-1:0]       in_valid,
  input  logic [N*WIDTH-1:0] in_data,
  output logic [N-1:0]       in_ready,
  output logic               out_valid,
  output logic [WIDTH-1:0]   out_data,
  output logic [SEL_W-1:0]   out_sel,
  input  logic               out_ready
);

  logic             load;
  logic             arb_en;
  logic [N-1:0]     gnt_onehot;
  logic [SEL_W-1:0] gnt_idx;
  logic             gnt_any;
  logic [WIDTH-1:0] gnt_data;
  logic [WIDTH-1:0] ch_data [N];

  logic             out_valid_reg, out_valid_next;
  logic [WIDTH-1:0] out_data_reg,  out_data_next;
  logic [SEL_W-1:0] out_sel_reg,   out_sel_next;
  logic [SEL_W-1:0] rr_ptr_reg,    rr_ptr_next;

  // The stage can take a new beat when empty or when its beat leaves now.
  assign load   = !out_valid_reg || out_ready;
  // No channel is accepted while reset is held.
  assign arb_en = load && rst_n;

  rr_arbiter #(
    .N    (N),
    .MODE (MODE)
  ) u_arbiter (
    .req        (in_valid),
    .ptr        (rr_ptr_reg),
    .en         (arb_en),
    .gnt_onehot (gnt_onehot),
    .gnt_idx    (gnt_idx),
    .gnt_any    (gnt_any)
  );

  // Grants only ever go to requesting channels, so a grant is a transfer.
  assign in_ready = gnt_onehot;

  // Unpack the flat data bus into per-channel words.
  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_unpack
      assign ch_data[gi] = in_data[gi*WIDTH +: WIDTH];
    end
  endgenerate

  // AND-OR select of the granted channel's data.
  always_comb begin
    gnt_data = '0;
    for (int i = 0; i < N; i++) begin
      if (gnt_onehot[i]) begin
        gnt_data = gnt_data | ch_data[i];
      end
    end
  end

  // Output stage and pointer next-state: load on grant, drain when idle.
  always_comb begin
    out_valid_next = out_valid_reg;
    out_data_next  = out_data_reg;
    out_sel_next   = out_sel_reg;
    rr_ptr_next    = rr_ptr_reg;
    if (load) begin
      out_valid_next = gnt_any;
      if (gnt_any) begin
        out_data_next = gnt_data;
        out_sel_next  = gnt_idx;
        if (MODE == ARB_RR) begin
          rr_ptr_next = (gnt_idx == SEL_W'(N - 1)) ? '0 : gnt_idx + SEL_W'(1);
        end
      end
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid_reg <= 1'b0;
      out_data_reg  <= '0;
      out_sel_reg   <= '0;
      rr_ptr_reg    <= '0;
    end else begin
      out_valid_reg <= out_valid_next;
      out_data_reg  <= out_data_next;
      out_sel_reg   <= out_sel_next;
      rr_ptr_reg    <= rr_ptr_next;
    end
  end

  assign out_valid = out_valid_reg;
  assign out_data  = out_data_reg;
  assign out_sel   = out_sel_reg;

endmodule
